// File: rtl/eth_tx_frame_arbiter.sv
// Two-requester AXI-Stream frame arbiter toward a MAC TX sink: round-robin
// per frame, zero-latency passthrough, and truncation of over-length frames.
module eth_tx_frame_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tvalid,
  input  logic                  s0_tlast,
  input  logic                  s0_tuser,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tvalid,
  input  logic                  s1_tlast,
  input  logic                  s1_tuser,
  output logic                  s1_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic                  m_tuser,
  input  logic                  m_tready,
  output logic [15:0]           frames0,
  output logic [15:0]           frames1,
  output logic                  trunc_pulse,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, GRANT, DROP} state_e;

  localparam logic [15:0] LAST_IDX = 16'(MAX_FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = s0, 1 = s1
  logic        last_q, last_d;     // last-served requester
  logic [1:0]  grant_q, grant_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] frames0_q, frames0_d;
  logic [15:0] frames1_q, frames1_d;
  logic        trunc_q, trunc_d;

  logic [DATA_WIDTH-1:0] own_data;
  logic own_valid, own_last, own_user;
  logic in_grant, in_drop, at_limit, accept, drop_done, winner;

  always_comb begin
    own_data  = owner_q ? s1_tdata  : s0_tdata;
    own_valid = owner_q ? s1_tvalid : s0_tvalid;
    own_last  = owner_q ? s1_tlast  : s0_tlast;
    own_user  = owner_q ? s1_tuser  : s0_tuser;
  end

  assign in_grant  = (state_q == GRANT);
  assign in_drop   = (state_q == DROP);
  // Beat that would exceed the length limit without ending the frame
  assign at_limit  = (beat_q == LAST_IDX) && !own_last;
  assign accept    = in_grant && own_valid && m_tready;
  assign drop_done = in_drop && own_valid && own_last;
  assign winner    = (s0_tvalid && s1_tvalid) ? ~last_q : s1_tvalid;

  always_comb begin
    m_tvalid  = in_grant && own_valid;
    m_tdata   = in_grant ? own_data : '0;
    m_tlast   = in_grant && own_valid && (own_last || at_limit);
    m_tuser   = in_grant && own_valid && (own_user || at_limit);
    s0_tready = !owner_q && ((in_grant && m_tready) || in_drop);
    s1_tready =  owner_q && ((in_grant && m_tready) || in_drop);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant_d   = grant_q;
    beat_d    = beat_q;
    frames0_d = frames0_q;
    frames1_d = frames1_q;
    trunc_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          state_d = GRANT;
          owner_d = winner;
          last_d  = winner;
          grant_d = winner ? 2'b10 : 2'b01;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_d = beat_q + 16'd1;
          if (own_last) begin
            state_d = IDLE;
            grant_d = 2'b00;
            if (owner_q) frames1_d = frames1_q + 16'd1;
            else         frames0_d = frames0_q + 16'd1;
          end else if (at_limit) begin
            state_d = DROP;
            trunc_d = 1'b1;
          end
        end
      end
      DROP: begin
        if (drop_done) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      beat_q    <= '0;
      frames0_q <= '0;
      frames1_q <= '0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      beat_q    <= beat_d;
      frames0_q <= frames0_d;
      frames1_q <= frames1_d;
      trunc_q   <= trunc_d;
    end
  end

  assign frames0     = frames0_q;
  assign frames1     = frames1_q;
  assign trunc_pulse = trunc_q;
  assign grant       = grant_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench: default-length and MAX_FRAME_LEN=16 instances share stimulus;
// a per-port scoreboard checks every beat of the selected instance.
module tb_eth_tx_frame_arbiter;
  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic          u;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DW-1:0] s0_tdata, s1_tdata;
  logic s0_tvalid, s0_tlast, s0_tuser, s1_tvalid, s1_tlast, s1_tuser, m_tready;
  logic sel;

  logic [DW-1:0] a_m_tdata, t_m_tdata, m_tdata;
  logic a_s0_tready, a_s1_tready, a_m_tvalid, a_m_tlast, a_m_tuser, a_trunc;
  logic t_s0_tready, t_s1_tready, t_m_tvalid, t_m_tlast, t_m_tuser, t_trunc;
  logic s0_tready, s1_tready, m_tvalid, m_tlast, m_tuser, trunc_pulse;
  logic [15:0] a_f0, a_f1, t_f0, t_f1, frames0, frames1;
  logic [1:0] a_grant, t_grant, grant;

  eth_tx_frame_arbiter #(.DATA_WIDTH(DW)) dut_a (
    .clk(clk), .reset(reset),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_tready(a_s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_tready(a_s1_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast), .m_tuser(a_m_tuser), .m_tready(m_tready),
    .frames0(a_f0), .frames1(a_f1), .trunc_pulse(a_trunc), .grant(a_grant));

  eth_tx_frame_arbiter #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(16)) dut_t (
    .clk(clk), .reset(reset),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_tready(t_s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_tready(t_s1_tready),
    .m_tdata(t_m_tdata), .m_tvalid(t_m_tvalid), .m_tlast(t_m_tlast), .m_tuser(t_m_tuser), .m_tready(m_tready),
    .frames0(t_f0), .frames1(t_f1), .trunc_pulse(t_trunc), .grant(t_grant));

  assign m_tdata     = sel ? t_m_tdata   : a_m_tdata;
  assign m_tvalid    = sel ? t_m_tvalid  : a_m_tvalid;
  assign m_tlast     = sel ? t_m_tlast   : a_m_tlast;
  assign m_tuser     = sel ? t_m_tuser   : a_m_tuser;
  assign s0_tready   = sel ? t_s0_tready : a_s0_tready;
  assign s1_tready   = sel ? t_s1_tready : a_s1_tready;
  assign frames0     = sel ? t_f0        : a_f0;
  assign frames1     = sel ? t_f1        : a_f1;
  assign trunc_pulse = sel ? t_trunc     : a_trunc;
  assign grant       = sel ? t_grant     : a_grant;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  beat_t q0[$], q1[$];
  int order[$];
  int out_beats, tlast_cnt, trunc_cnt, out_idx;
  int start_cyc, first_out_cyc, trunc_cyc, tlast_cyc;
  bit chk_off, mirror_chk, bp_done;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the owning port's expected queue on every accepted beat
  always @(negedge clk) begin
    if (!reset) begin
      if (trunc_pulse) begin
        trunc_cnt++;
        trunc_cyc = cyc;
      end
      if (mirror_chk && grant == 2'b10)
        chk("s1_mirror", {30'd0, s1_tready, s0_tready}, {30'd0, m_tready, 1'b0});
      if (m_tvalid && m_tready) begin
        if (out_idx == 0) first_out_cyc = cyc;
        out_beats++;
        if (!chk_off) begin
          int p;
          int qsz;
          beat_t e;
          p = (grant == 2'b10) ? 1 : 0;
          chk("grant_onehot", {30'd0, grant}, p ? 32'd2 : 32'd1);
          qsz = p ? q1.size() : q0.size();
          total++;
          assert (qsz != 0) else begin
            bad++;
            $error("FAIL sb_underflow port=%0d observed_beat=%0h expected=none", p, {m_tdata, m_tlast, m_tuser});
          end
          if (qsz != 0) begin
            e = p ? q1.pop_front() : q0.pop_front();
            chk("beat", {22'd0, m_tdata, m_tlast, m_tuser}, {22'd0, e.d, e.l, e.u});
          end
          if (m_tlast) order.push_back(p);
        end
        if (m_tlast) begin
          tlast_cnt++;
          tlast_cyc = cyc;
          out_idx = 0;
        end else begin
          out_idx++;
        end
      end
    end
  end

  task automatic drive(input int p, input bit v, input beat_t b);
    if (p == 0) begin
      s0_tvalid = v; s0_tdata = b.d; s0_tlast = b.l; s0_tuser = b.u;
    end else begin
      s1_tvalid = v; s1_tdata = b.d; s1_tlast = b.l; s1_tuser = b.u;
    end
  endtask

  // Sends one frame; expected output (with truncation model) is queued up front
  task automatic send(input int p, input int n, input bit ul);
    beat_t fr[$];
    beat_t b, e;
    int mx;
    bit ok;
    mx = sel ? 16 : 1518;
    for (int i = 0; i < n; i++) begin
      b.d = 8'($urandom_range(0, 255));
      b.l = (i == n - 1);
      b.u = ul && (i == n - 1);
      fr.push_back(b);
      if (i < mx) begin
        e = b;
        if (i == mx - 1 && !b.l) begin
          e.l = 1'b1;
          e.u = 1'b1;
        end
        if (p == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    start_cyc = cyc;
    foreach (fr[i]) begin
      drive(p, 1'b1, fr[i]);
      ok = 1'b0;
      for (int w = 0; w < 200 && !ok; w++) begin
        @(negedge clk);
        ok = (p == 0) ? s0_tready : s1_tready;
      end
      chk("handshake_timeout", {31'd0, ok}, 32'd1);
      if (!ok) break;
      @(posedge clk);
      #1;
    end
    drive(p, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    q0.delete(); q1.delete(); order.delete();
    out_beats = 0; tlast_cnt = 0; trunc_cnt = 0; out_idx = 0;
  endtask

  function automatic logic [31:0] order_code();
    logic [31:0] r;
    r = 32'(order.size()) << 8;
    foreach (order[i]) r[3 - i] = order[i][0];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; m_tready = 1'b1;
    chk_off = 0; mirror_chk = 0; bp_done = 0;
    out_beats = 0; tlast_cnt = 0; trunc_cnt = 0; out_idx = 0;
    s0_tdata = '0; s1_tdata = '0;
    s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tuser = 1'b1;
    s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tuser = 1'b1;

    // Outputs quiet while held in reset, even with requests pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {27'd0, m_tvalid, m_tlast, m_tuser, s0_tready, s1_tready}, 32'd0);
    chk("rst_state", {frames0, frames1} , 32'd0);
    chk("rst_grant_trunc", {29'd0, grant, trunc_pulse}, 32'd0);
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    @(posedge clk); #1 reset = 1'b0;

    // Single requester, 64-beat frame
    send(0, 64, 1'b0);
    @(negedge clk); #1;
    chk("t1_frames", {frames0, frames1}, {16'd1, 16'd0});
    chk("t1_latency", 32'(first_out_cyc - start_cyc), 32'd1);
    chk("t1_beats", 32'(out_beats), 32'd64);
    chk("t1_q_empty", 32'(q0.size()), 32'd0);

    // Contention, both continuously sending 10-beat frames
    do_reset();
    fork
      begin send(0, 10, 1'b0); send(0, 10, 1'b0); end
      begin send(1, 10, 1'b0); send(1, 10, 1'b0); end
    join
    @(negedge clk); #1;
    chk("t2_order", order_code(), {24'd4, 8'b0101});
    chk("t2_frames", {frames0, frames1}, {16'd2, 16'd2});
    chk("t2_q_empty", 32'(q0.size() + q1.size()), 32'd0);

    // Backpressure on s1
    do_reset();
    bp_done = 0; mirror_chk = 1;
    fork
      begin send(1, 12, 1'b0); bp_done = 1; end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          if (!bp_done) m_tready = ~m_tready;
        end
      end
    join
    mirror_chk = 0; m_tready = 1'b1;
    @(negedge clk); #1;
    chk("t3_frames", {frames0, frames1}, {16'd0, 16'd1});
    chk("t3_beats", 32'(out_beats), 32'd12);
    chk("t3_q_empty", 32'(q1.size()), 32'd0);

    // Truncation at MAX_FRAME_LEN=16
    sel = 1'b1;
    do_reset();
    send(0, 20, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("t4_beats", 32'(out_beats), 32'd16);
    chk("t4_trunc_cnt", 32'(trunc_cnt), 32'd1);
    chk("t4_trunc_timing", 32'(trunc_cyc - tlast_cyc), 32'd1);
    chk("t4_frames", {frames0, frames1}, 32'd0);
    chk("t4_q_empty", 32'(q0.size()), 32'd0);

    // Exact-length frame, then tuser passthrough on a normal frame
    do_reset();
    send(0, 16, 1'b0);
    send(1, 5, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("t5_trunc_cnt", 32'(trunc_cnt), 32'd0);
    chk("t5_frames", {frames0, frames1}, {16'd1, 16'd1});
    chk("t5_beats", 32'(out_beats), 32'd21);
    chk("t5_q_empty", 32'(q0.size() + q1.size()), 32'd0);

    // Reset in the middle of an s1 frame
    sel = 1'b0;
    do_reset();
    chk_off = 1;
    s1_tdata = 8'h5a; s1_tlast = 1'b0; s1_tuser = 1'b0; s1_tvalid = 1'b1;
    for (int w = 0; w < 50 && out_beats < 5; w++) begin
      @(negedge clk); #1;
    end
    chk("t6_reached_beat5", 32'(out_beats >= 5), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; s1_tvalid = 1'b0;
    @(negedge clk); #1;
    chk("t6_after_rst", {28'd0, grant, m_tvalid, m_tlast}, 32'd0);
    chk("t6_counters", {frames0, frames1}, 32'd0);
    chk("t6_no_tlast", 32'(tlast_cnt), 32'd0);
    q0.delete(); q1.delete(); order.delete();
    out_beats = 0; out_idx = 0; chk_off = 0;
    fork
      send(0, 6, 1'b0);
      send(1, 6, 1'b0);
    join
    @(negedge clk); #1;
    chk("t6_order", order_code(), {24'd2, 8'b0100});
    chk("t6_frames", {frames0, frames1}, {16'd1, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the AXI-Stream tdata width in bits (one beat = one byte at 8).
REQ-002 SHALL have parameter MAX_FRAME_LEN, default 1518, giving the maximum beats per frame before forced truncation; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-005 SHALL have ports s0_tdata/s1_tdata, input, DATA_WIDTH, requester payload.
REQ-006 SHALL have ports s0_tvalid/s1_tvalid, s0_tlast/s1_tlast, s0_tuser/s1_tuser, input, 1 each, requester handshake, end-of-frame and error flags.
REQ-007 SHALL have ports s0_tready/s1_tready, output, 1 each, requester ready.
REQ-008 SHALL have ports m_tdata (output, DATA_WIDTH), m_tvalid, m_tlast, m_tuser (output, 1 each), and m_tready (input, 1), the stream toward the MAC TX sink.
REQ-009 SHALL have ports frames0/frames1, output, 16, completed-frame counts per requester.
REQ-010 SHALL have port trunc_pulse, output, 1, a one-cycle strobe per truncated frame.
REQ-011 SHALL have port grant, output, 2, one-hot current owner (00 = none).

Function
REQ-012 SHALL implement states IDLE, GRANT and DROP.
REQ-013 In IDLE, SHALL drive m_tvalid=0 and s0_tready=s1_tready=0.
REQ-014 In IDLE with any s*_tvalid=1, SHALL select an owner, enter GRANT on the next cycle, and set grant one-hot, giving a 1-cycle arbitration bubble.
REQ-015 On contention, SHALL select round-robin: the requester not served last wins; after reset, last-served = 1, so port 0 wins first contention.
REQ-016 A single valid requester SHALL win regardless of the round-robin pointer; the pointer updates to the winner when GRANT is entered.
REQ-017 In GRANT, SHALL pass through combinationally with zero latency: m_tdata/m_tvalid/m_tlast/m_tuser = owner's signals; owner s_tready = m_tready; non-owner s_tready = 0.
REQ-018 SHALL hold ownership until the owner beat with tlast=1 is accepted (m_tvalid & m_tready); it SHALL then return to IDLE and increment the owner's frames counter (16-bit, wraps 65535->0).
REQ-019 SHALL keep a 16-bit beat counter, cleared on GRANT entry and incremented per accepted beat.
REQ-020 When an accepted beat has counter = MAX_FRAME_LEN-1 and owner tlast=0, SHALL force m_tlast=1 and m_tuser=1 on that beat, pulse trunc_pulse the following cycle, and enter DROP; the frame is not counted in frames*.
REQ-021 A beat at counter = MAX_FRAME_LEN-1 with owner tlast=1 SHALL pass unmodified, with no truncation.
REQ-022 In DROP, SHALL drive m_tvalid=0 and owner s_tready=1, discarding owner beats until one with tlast=1 is accepted, then go to IDLE; grant is held through DROP.
REQ-023 SHALL pass owner tuser=1 on a normal frame through unmodified, and count that frame.
REQ-024 A requester deasserting tvalid mid-frame SHALL NOT release ownership.

Reset
REQ-025 While reset=1 at a clk edge, SHALL go to IDLE, clear frames0/frames1, the beat counter, grant and trunc_pulse to 0, and set last-served = 1.
REQ-026 During and after reset, outputs SHALL be m_tvalid=0, m_tlast=0, m_tuser=0, s*_tready=0.
REQ-027 Reset mid-frame SHALL abandon the frame without emitting m_tlast; the next frame arbitrates fresh.

Verification
REQ-028 Single requester: s0 sends a 64-beat frame, m_tready=1 -> 64 beats appear unchanged starting 1 cycle after s0_tvalid, last beat tlast=1, frames0=1, grant=01 during the frame.
REQ-029 Contention: both requesters continuously send 10-beat frames -> output order s0,s1,s0,s1, no interleaving within a frame, frames0=frames1=2 after 4 frames.
REQ-030 Backpressure: m_tready toggles 1/0 each cycle during a frame from s1 -> s1_tready mirrors m_tready, no beat lost or duplicated, grant fixed at 10.
REQ-031 Truncation: MAX_FRAME_LEN=16, s0 sends 20 beats -> 16 beats out, beat 16 with tlast=1 and tuser=1, trunc_pulse for 1 cycle, 4 beats absorbed with m_tvalid=0, frames0 unchanged.
REQ-032 Exact length: MAX_FRAME_LEN=16, 16-beat frame -> no truncation, tuser=0, frames0 increments.
REQ-033 Reset mid-frame: reset at beat 5 of an s1 frame -> next cycle grant=00, m_tvalid=0, counters 0; subsequent contention grants s0 first.
